// File: rtl/mem_req_pkg.sv
// mem_req_pkg: request type, default widths and sizing helper for the memory request queue
package mem_req_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] address;
    logic [DEF_DATA_W-1:0] data;
  } req_t;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: synchronous in-order FIFO of request structs with occupancy count
module mem_req_fifo
  import mem_req_pkg::*;
#(
  parameter type T = req_t,
  parameter int DEPTH = 8,
  localparam int AW = clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  T            din,
  output T            dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  T mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/mem_req_queue.sv
// mem_req_queue: in-order request queue feeding the memory controller, with
// outstanding-request throttling, a read-after-write fence and registered returns.
module mem_req_queue
  import mem_req_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [DATA_W-1:0] req_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_address,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ret_ack,
  input  logic [ADDR_W-1:0] wr_ret_address,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_address,
  input  logic              rd_ret_ack,
  input  logic [ADDR_W-1:0] rd_ret_address,
  input  logic [DATA_W-1:0] rd_ret_data,
  output logic              wr_resp_valid,
  output logic [ADDR_W-1:0] wr_resp_address,
  output logic              rd_resp_valid,
  output logic [ADDR_W-1:0] rd_resp_address,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              busy,
  output logic              spurious_ack
);
  localparam int AW = clog2(DEPTH);
  req_t din, head;
  logic full, empty, issue, wr_issue, rd_issue, wr_dec, rd_dec;
  logic [AW:0] count;
  logic [3:0] wr_cnt, rd_cnt;
  assign din = '{we: req_we, address: req_address, data: req_data};
  // Reads wait for every issued write to complete so they never overtake one.
  assign issue = !empty && ({1'b0, wr_cnt} + {1'b0, rd_cnt} < 5'(MAX_OUTSTANDING))
                 && (head.we || wr_cnt == '0);
  assign wr_issue = issue && head.we;
  assign rd_issue = issue && !head.we;
  assign wr_dec = wr_ret_ack && wr_cnt != '0;
  assign rd_dec = rd_ret_ack && rd_cnt != '0;
  assign req_ready = !full;
  assign busy = count != '0 || wr_cnt != '0 || rd_cnt != '0;
  mem_req_fifo #(.T(req_t), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_valid),
    .pop   (issue),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      wr_address <= '0;
      wr_data <= '0;
      rd_address <= '0;
      wr_resp_valid <= 1'b0;
      wr_resp_address <= '0;
      rd_resp_valid <= 1'b0;
      rd_resp_address <= '0;
      rd_resp_data <= '0;
      spurious_ack <= 1'b0;
    end else begin
      wr_cnt <= wr_cnt + 4'(wr_issue) - 4'(wr_dec);
      rd_cnt <= rd_cnt + 4'(rd_issue) - 4'(rd_dec);
      wr_en <= wr_issue;
      rd_en <= rd_issue;
      if (wr_issue) begin
        wr_address <= head.address;
        wr_data <= head.data;
      end
      if (rd_issue) rd_address <= head.address;
      wr_resp_valid <= wr_ret_ack;
      wr_resp_address <= wr_ret_address;
      rd_resp_valid <= rd_ret_ack;
      rd_resp_address <= rd_ret_address;
      rd_resp_data <= rd_ret_data;
      spurious_ack <= spurious_ack | (wr_ret_ack && wr_cnt == '0) | (rd_ret_ack && rd_cnt == '0);
    end
  end
endmodule

// File: tb/tb_mem_req_queue.sv
// tb_mem_req_queue: directed scenario bench for mem_req_queue
module tb_mem_req_queue;
  logic clk, reset;
  logic req_valid, req_ready, req_we;
  logic [15:0] req_address, req_data;
  logic wr_en, rd_en, wr_ret_ack, rd_ret_ack;
  logic [15:0] wr_address, wr_data, wr_ret_address, rd_address, rd_ret_address, rd_ret_data;
  logic wr_resp_valid, rd_resp_valid, busy, spurious_ack;
  logic [15:0] wr_resp_address, rd_resp_address, rd_resp_data;
  int errors = 0;
  int checks = 0;

  mem_req_queue #(.ADDR_W(16), .DATA_W(16), .DEPTH(8), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_address(req_address), .req_data(req_data), .wr_en(wr_en), .wr_address(wr_address),
    .wr_data(wr_data), .wr_ret_ack(wr_ret_ack), .wr_ret_address(wr_ret_address), .rd_en(rd_en),
    .rd_address(rd_address), .rd_ret_ack(rd_ret_ack), .rd_ret_address(rd_ret_address),
    .rd_ret_data(rd_ret_data), .wr_resp_valid(wr_resp_valid), .wr_resp_address(wr_resp_address),
    .rd_resp_valid(rd_resp_valid), .rd_resp_address(rd_resp_address), .rd_resp_data(rd_resp_data),
    .busy(busy), .spurious_ack(spurious_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle;
    req_valid = 0; req_we = 0; req_address = '0; req_data = '0;
    wr_ret_ack = 0; wr_ret_address = '0; rd_ret_ack = 0; rd_ret_address = '0; rd_ret_data = '0;
  endtask

  task automatic do_reset;
    idle;
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset;
    idle;
    reset = 1;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready got %b want 1", req_ready); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset wr_en got %b want 0", wr_en); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset rd_en got %b want 0", rd_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    checks++; if (spurious_ack !== 1'b0) begin errors++; $display("FAIL reset spurious got %b want 0", spurious_ack); end
    checks++; if ({wr_resp_valid, rd_resp_valid} !== 2'b00) begin errors++; $display("FAIL reset resp_valid got %b want 00", {wr_resp_valid, rd_resp_valid}); end
    checks++; if (rd_resp_data !== 16'h0) begin errors++; $display("FAIL reset rd_resp_data got %h want 0000", rd_resp_data); end
    reset = 0;
  endtask

  task automatic test_reads;
    do_reset;
    for (int c = 0; c < 8; c++) begin
      logic en_exp, rv_exp;
      en_exp = c >= 2 && c <= 4;
      rv_exp = c >= 3 && c <= 5;
      checks++; if (rd_en !== en_exp) begin errors++; $display("FAIL reads rd_en c=%0d got %b want %b", c, rd_en, en_exp); end
      if (en_exp) begin
        checks++; if (rd_address !== 16'(16'h10 + c - 2)) begin errors++; $display("FAIL reads rd_address c=%0d got %h want %h", c, rd_address, 16'(16'h10 + c - 2)); end
      end
      checks++; if (rd_resp_valid !== rv_exp) begin errors++; $display("FAIL reads rd_resp_valid c=%0d got %b want %b", c, rd_resp_valid, rv_exp); end
      if (rv_exp) begin
        checks++; if (rd_resp_data !== 16'((16'h10 + c - 3) ^ 16'hA5A5)) begin errors++; $display("FAIL reads rd_resp_data c=%0d got %h want %h", c, rd_resp_data, 16'((16'h10 + c - 3) ^ 16'hA5A5)); end
        checks++; if (rd_resp_address !== 16'(16'h10 + c - 3)) begin errors++; $display("FAIL reads rd_resp_address c=%0d got %h want %h", c, rd_resp_address, 16'(16'h10 + c - 3)); end
      end
      if (c == 7) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reads busy end got %b want 0", busy); end
      end
      req_valid = c < 3; req_we = 0; req_address = 16'(16'h10 + c);
      rd_ret_ack = en_exp; rd_ret_address = 16'(16'h10 + c - 2); rd_ret_data = 16'((16'h10 + c - 2) ^ 16'hA5A5);
      @(negedge clk);
    end
    idle;
  endtask

  task automatic test_raw_fence;
    do_reset;
    for (int c = 0; c < 12; c++) begin
      checks++; if (wr_en !== (c == 2)) begin errors++; $display("FAIL raw wr_en c=%0d got %b want %b", c, wr_en, c == 2); end
      checks++; if (rd_en !== (c == 9)) begin errors++; $display("FAIL raw rd_en c=%0d got %b want %b", c, rd_en, c == 9); end
      checks++; if (wr_resp_valid !== (c == 8)) begin errors++; $display("FAIL raw wr_resp_valid c=%0d got %b want %b", c, wr_resp_valid, c == 8); end
      if (c == 2) begin
        checks++; if ({wr_address, wr_data} !== {16'h0020, 16'hBEEF}) begin errors++; $display("FAIL raw wr_addr_data got %h/%h want 0020/beef", wr_address, wr_data); end
      end
      if (c == 5) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL raw busy mid got %b want 1", busy); end
      end
      if (c == 8) begin
        checks++; if (wr_resp_address !== 16'h0020) begin errors++; $display("FAIL raw wr_resp_address got %h want 0020", wr_resp_address); end
      end
      if (c == 9) begin
        checks++; if (rd_address !== 16'h0020) begin errors++; $display("FAIL raw rd_address got %h want 0020", rd_address); end
      end
      if (c == 10) begin
        checks++; if ({rd_resp_valid, rd_resp_data} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL raw rd_resp got %b/%h want 1/1234", rd_resp_valid, rd_resp_data); end
      end
      if (c == 11) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL raw busy end got %b want 0", busy); end
      end
      req_valid = c < 2; req_we = c == 0; req_address = 16'h0020; req_data = 16'hBEEF;
      wr_ret_ack = c == 7; wr_ret_address = 16'h0020;
      rd_ret_ack = c == 9; rd_ret_address = 16'h0020; rd_ret_data = 16'h1234;
      @(negedge clk);
    end
    idle;
  endtask

  task automatic test_max_outstanding;
    do_reset;
    for (int c = 0; c < 16; c++) begin
      logic en_exp;
      en_exp = (c >= 2 && c <= 5) || c == 13;
      checks++; if (rd_en !== en_exp) begin errors++; $display("FAIL maxout rd_en c=%0d got %b want %b", c, rd_en, en_exp); end
      if (en_exp) begin
        checks++; if (rd_address !== 16'(16'h30 + (c == 13 ? 4 : c - 2))) begin errors++; $display("FAIL maxout rd_address c=%0d got %h want %h", c, rd_address, 16'(16'h30 + (c == 13 ? 4 : c - 2))); end
      end
      if (c == 15) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL maxout busy end got %b want 1", busy); end
      end
      req_valid = c < 6; req_we = 0; req_address = 16'(16'h30 + c);
      rd_ret_ack = c == 11; rd_ret_address = 16'h0030;
      @(negedge clk);
    end
    idle;
  endtask

  task automatic test_fill_wrap;
    int pushed = 0;
    int nrd = 0;
    int nwr = 0;
    do_reset;
    for (int c = 0; c < 60; c++) begin
      if (c == 19) begin
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fill req_ready full got %b want 0", req_ready); end
        checks++; if (nrd !== 0) begin errors++; $display("FAIL fill fenced reads issued got %0d want 0", nrd); end
      end
      if (rd_en === 1'b1) begin
        checks++; if (rd_address !== 16'(16'h50 + nrd)) begin errors++; $display("FAIL fill rd order n=%0d got %h want %h", nrd, rd_address, 16'(16'h50 + nrd)); end
        nrd++;
      end
      if (wr_en === 1'b1) nwr++;
      rd_ret_ack = rd_en; rd_ret_address = rd_address; rd_ret_data = 16'h0;
      wr_ret_ack = c == 20; wr_ret_address = 16'h0040;
      req_valid = pushed < 10; req_we = pushed == 0;
      req_address = pushed == 0 ? 16'h0040 : 16'(16'h50 + pushed - 1);
      req_data = 16'(16'h1000 + pushed);
      if (req_valid && req_ready) pushed++;
      @(negedge clk);
    end
    idle;
    checks++; if (nwr !== 1) begin errors++; $display("FAIL fill wr_en pulses got %0d want 1", nwr); end
    checks++; if (nrd !== 9) begin errors++; $display("FAIL fill rd_en pulses got %0d want 9", nrd); end
    checks++; if (pushed !== 10) begin errors++; $display("FAIL fill accepted got %0d want 10", pushed); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill busy end got %b want 0", busy); end
    checks++; if (spurious_ack !== 1'b0) begin errors++; $display("FAIL fill spurious got %b want 0", spurious_ack); end
  endtask

  task automatic test_dual_ack;
    do_reset;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) begin
        checks++; if ({wr_en, busy} !== 2'b11) begin errors++; $display("FAIL dual pre wr_en/busy got %b want 11", {wr_en, busy}); end
      end
      if (c == 4) begin
        checks++; if ({wr_resp_valid, rd_resp_valid} !== 2'b11) begin errors++; $display("FAIL dual resp_valid got %b want 11", {wr_resp_valid, rd_resp_valid}); end
        checks++; if ({wr_resp_address, rd_resp_data} !== {16'h0071, 16'hCAFE}) begin errors++; $display("FAIL dual resp data got %h/%h want 0071/cafe", wr_resp_address, rd_resp_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dual busy got %b want 0", busy); end
        checks++; if (spurious_ack !== 1'b0) begin errors++; $display("FAIL dual spurious got %b want 0", spurious_ack); end
      end
      if (c == 5) begin
        checks++; if ({wr_resp_valid, rd_resp_valid} !== 2'b00) begin errors++; $display("FAIL dual resp_valid after got %b want 00", {wr_resp_valid, rd_resp_valid}); end
      end
      req_valid = c < 2; req_we = c == 1; req_address = c == 0 ? 16'h0070 : 16'h0071; req_data = 16'h7777;
      wr_ret_ack = c == 3; wr_ret_address = 16'h0071;
      rd_ret_ack = c == 3; rd_ret_address = 16'h0070; rd_ret_data = 16'hCAFE;
      @(negedge clk);
    end
    idle;
  endtask

  task automatic test_spurious;
    do_reset;
    rd_ret_ack = 1; rd_ret_address = 16'h0099; rd_ret_data = 16'h0055;
    @(negedge clk);
    rd_ret_ack = 0;
    checks++; if ({spurious_ack, busy, rd_resp_valid} !== 3'b101) begin errors++; $display("FAIL spur idle ack got %b want 101", {spurious_ack, busy, rd_resp_valid}); end
    @(negedge clk);
    checks++; if (spurious_ack !== 1'b1) begin errors++; $display("FAIL spur sticky got %b want 1", spurious_ack); end
    do_reset;
    checks++; if (spurious_ack !== 1'b0) begin errors++; $display("FAIL spur cleared got %b want 0", spurious_ack); end
    for (int c = 0; c < 4; c++) begin
      req_valid = c < 3; req_we = 0; req_address = 16'(16'h80 + c);
      @(negedge clk);
    end
    checks++; if ({rd_en, busy} !== 2'b11) begin errors++; $display("FAIL spur in flight rd_en/busy got %b want 11", {rd_en, busy}); end
    #1 reset = 1;
    #1;
    checks++; if ({rd_en, busy, req_ready, spurious_ack} !== 4'b0010) begin errors++; $display("FAIL spur async reset got %b want 0010", {rd_en, busy, req_ready, spurious_ack}); end
    @(negedge clk);
    reset = 0;
    rd_ret_ack = 1; rd_ret_address = 16'h0082; rd_ret_data = 16'h0011;
    @(negedge clk);
    rd_ret_ack = 0;
    checks++; if ({spurious_ack, busy, rd_en} !== 3'b100) begin errors++; $display("FAIL spur late ack got %b want 100", {spurious_ack, busy, rd_en}); end
    repeat (3) @(negedge clk);
    checks++; if ({rd_en, busy} !== 2'b00) begin errors++; $display("FAIL spur dropped queue rd_en/busy got %b want 00", {rd_en, busy}); end
  endtask

  initial begin
    test_reset;
    test_reads;
    test_raw_fence;
    test_max_outstanding;
    test_fill_wrap;
    test_dual_ack;
    test_spurious;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
